div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the MIPS execute stage.
- Serves DIV/DIVU, which the single-cycle ALU does not implement.
- Radix-2 restoring algorithm, one quotient bit per cycle; the pipeline stalls while busy.
- The result feeds the HI/LO register pair: HI = remainder, LO = quotient.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a divide; held high by the stall logic until ready is seen.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- annul  in  1  flush (exception/branch squash); aborts the operation in flight.
- a  in  WIDTH  dividend (rs); sampled when a start is accepted.
- b  in  WIDTH  divisor (rt); sampled when a start is accepted.
- result  out  2*WIDTH  {remainder, quotient}; [63:32] to HI, [31:0] to LO.
- ready  out  1  result valid; equals (state == END).
- busy  out  1  state != IDLE; drives the pipeline stall.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, partial remainder/quotient/divisor regs=0.
  - result=0, ready=0, busy=0, immediately, regardless of clk.
  - This holds mid-operation too; no partial result survives.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - The edge that samples start=1 with annul=0 accepts the request.
  - Latches operands; if signed_div=1, stores |a|, |b|, sign(a), sign(a)^sign(b).
  - b==0 goes to DIVZERO; otherwise goes to ON with counter=0 and the working remainder cleared.
  - start with annul=1 is ignored; the block stays in IDLE.
- ON: each edge performs one restoring step:
  - Shift the remainder left 1 and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor.
  - If the difference is non-negative, keep it and set the quotient bit to 1; else restore and set the quotient bit to 0.
  - counter increments each step.
  - The edge performing step WIDTH (counter==WIDTH-1) also applies sign fixup, registers result, and goes to END.
  - Sign fixup: quotient is negated when the sign-xor is set; remainder is negated when the dividend was negative, so the remainder takes the dividend's sign. Both apply only when signed_div=1.
- DIVZERO: one cycle, then END with result=0 (HI=0, LO=0). There is no trap; MIPS leaves this case undefined and we define it as 0.
- END:
  - ready=1 and result is held stable.
  - Stays in END while start=1.
  - When start=0, returns to IDLE on the next edge and result clears to 0.
  - If start is held high across END, the next divide needs start deasserted for at least one cycle.
- annul=1 in ON or DIVZERO returns to IDLE on the next edge. ready never asserts and result stays 0. annul in END is ignored; the result is already committed to the stall release.
- Latency, counting the accepting edge as edge 1:
  - Normal divide: ready high after edge 33.
  - Divide by zero: ready high after edge 2.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the unsigned core plus negation; no special case and no overflow flag.
- The subtract is done at WIDTH+1 bits; the sign of the trial difference selects restore.

Decomposition:
- Add EXE_DIV_OP and EXE_DIVU_OP opcodes to defines.vh alongside the existing EXE_*_OP codes.
- Add the state encodings there as well (DIV_FREE/DIV_ZERO/DIV_ON/DIV_END, 2 bits).
- Decode of the opcode into start/signed_div stays in the execute-stage wrapper, not in div_unit.
- One natural combinational sub-module: div_step. It takes {remainder, next_bit, divisor} and returns {new_remainder, q_bit}, instantiated once.

Test Plan:
- Unsigned 100/7, start held → ready after edge 33; result[31:0]=0x0000000E, result[63:32]=0x00000002.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Signed 7/-2 → LO=0xFFFFFFFD, HI=0x00000001.
- b=0, any a → ready after edge 2, result=0. Drop start → IDLE next edge, ready=0, result=0.
- Annul at edge 10 of an operation → IDLE, ready never asserts. Then unsigned 0xFFFFFFFF/0x10 → LO=0x0FFFFFFF, HI=0x0000000F at edge 33.
- Signed 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. Unsigned 0x80000000/0xFFFFFFFF → LO=0, HI=0x80000000.
- rst pulsed between clock edges mid-ON → result=0, ready=0, busy=0 immediately. A subsequent 9/3 → LO=3, HI=0 with full 33-edge latency.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: opcode codes and FSM state encoding.
package div_unit_pkg;

   localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

   typedef enum logic [1:0] {
      DIV_FREE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } divState_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             nextBit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] newRem,
   output logic             qBit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The remainder is always below the divisor, so bit WIDTH of the difference is its sign.
   always_comb begin
      shifted = {rem, nextBit};
      diff    = shifted - {1'b0, divisor};
      qBit    = ~diff[WIDTH];
      newRem  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; result is {remainder (HI), quotient (LO)}.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic               annul,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               busy
);

   divState_t state, nextState;

   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   remReg;
   logic [WIDTH-1:0]   quoReg;
   logic [WIDTH-1:0]   divisorReg;
   logic               negQuo;
   logic               negRem;
   logic [2*WIDTH-1:0] resultReg;

   logic [WIDTH-1:0] stepRem;
   logic             qBit;
   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH-1:0] finalQuo;
   logic [WIDTH-1:0] fixQuo;
   logic [WIDTH-1:0] fixRem;
   logic             accept;
   logic             lastStep;

   // quoReg starts as the dividend and fills with quotient bits as dividend bits shift out.
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (remReg),
      .nextBit (quoReg[WIDTH-1]),
      .divisor (divisorReg),
      .newRem  (stepRem),
      .qBit    (qBit)
   );

   assign absA     = (signed_div && a[WIDTH-1]) ? -a : a;
   assign absB     = (signed_div && b[WIDTH-1]) ? -b : b;
   assign accept   = (state == DIV_FREE) && start && !annul;
   assign lastStep = (count == CNT_W'(WIDTH - 1));
   assign finalQuo = {quoReg[WIDTH-2:0], qBit};
   assign fixQuo   = negQuo ? -finalQuo : finalQuo;
   assign fixRem   = negRem ? -stepRem : stepRem;

   assign result = resultReg;
   assign ready  = (state == DIV_END);
   assign busy   = (state != DIV_FREE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DIV_FREE;
      else     state <= nextState;
   end

   // Next-state logic; annul only matters while the result is not yet committed.
   always_comb begin
      nextState = state;
      case (state)
         DIV_FREE: if (start && !annul) nextState = (b == '0) ? DIV_ZERO : DIV_ON;
         DIV_ZERO: nextState = annul ? DIV_FREE : DIV_END;
         DIV_ON: begin
            if (annul)         nextState = DIV_FREE;
            else if (lastStep) nextState = DIV_END;
         end
         DIV_END:  if (!start) nextState = DIV_FREE;
         default:  nextState = DIV_FREE;
      endcase
   end

   // Datapath: operand capture, one restoring step per ON cycle, sign fixup on the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         remReg     <= '0;
         quoReg     <= '0;
         divisorReg <= '0;
         negQuo     <= 1'b0;
         negRem     <= 1'b0;
         resultReg  <= '0;
      end else begin
         case (state)
            DIV_FREE: begin
               if (accept) begin
                  quoReg     <= absA;
                  divisorReg <= absB;
                  remReg     <= '0;
                  count      <= '0;
                  negQuo     <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                  negRem     <= signed_div & a[WIDTH-1];
               end
            end
            DIV_ZERO: resultReg <= '0;
            DIV_ON: begin
               if (!annul) begin
                  remReg <= stepRem;
                  quoReg <= finalQuo;
                  count  <= count + CNT_W'(1);
                  if (lastStep) resultReg <= {fixRem, fixQuo};
               end
            end
            DIV_END: if (!start) resultReg <= '0;
            default: ;
         endcase
      end
   end

endmodule
